// File: rtl/tetris_board_store.sv
// tetris_board_store
// Holds the BOARD_W x BOARD_H Tetris playfield (4-bit cell kind per cell) and
// serves three clients:
//   - display read : disp_x/disp_y -> disp_kind, 1-cycle latency, with the
//                    active falling piece overlaid on top of stored cells
//   - collision    : q_x/q_y (4 cells) -> q_collide, 1-cycle latency,
//                    stored cells and playfield bounds only
//   - lock         : lock_valid/lock_ready handshake writes 4 cells, then a
//                    sequential scan/compaction removes full rows
// Ports:
//   clk, reset_n                       clock, synchronous active-low reset
//   disp_x, disp_y, disp_kind          display query / registered answer
//   piece_valid, piece_kind,
//   piece_x, piece_y                   active piece overlay
//   q_x, q_y, q_collide                collision probe / registered answer
//   lock_valid, lock_ready, lock_kind,
//   lock_x, lock_y                     lock request handshake and payload
//   busy, clear_done, lines_cleared    clear engine status

module tetris_board_store #(
    parameter int unsigned BOARD_W = 10,
    parameter int unsigned BOARD_H = 20
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [4:0]      disp_x,
    input  logic [4:0]      disp_y,
    output logic [3:0]      disp_kind,
    input  logic            piece_valid,
    input  logic [3:0]      piece_kind,
    input  logic [3:0][4:0] piece_x,
    input  logic [3:0][4:0] piece_y,
    input  logic [3:0][4:0] q_x,
    input  logic [3:0][4:0] q_y,
    output logic            q_collide,
    input  logic            lock_valid,
    output logic            lock_ready,
    input  logic [3:0]      lock_kind,
    input  logic [3:0][4:0] lock_x,
    input  logic [3:0][4:0] lock_y,
    output logic            busy,
    output logic            clear_done,
    output logic [2:0]      lines_cleared
);

    localparam int unsigned CW    = 5;   // coordinate width
    localparam int unsigned KW    = 4;   // cell kind width
    localparam int unsigned NW    = 3;   // line counter width
    localparam int unsigned NCELL = 4;   // cells per piece / probe / lock
    localparam int unsigned XW    = (BOARD_W > 1) ? $clog2(BOARD_W) : 1;

    localparam logic [CW-1:0] W_LIM   = CW'(BOARD_W);
    localparam logic [CW-1:0] H_LIM   = CW'(BOARD_H);
    localparam logic [CW-1:0] BOTTOM  = CW'(BOARD_H - 1);
    localparam logic [NW-1:0] CNT_MAX = NW'(4);

    typedef logic [BOARD_W-1:0][KW-1:0] row_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;

    row_t            board [BOARD_H];
    logic [CW-1:0]   src_row;
    logic [CW-1:0]   dst_row;
    logic [NW-1:0]   line_cnt;
    logic [NW-1:0]   fill_left;

    logic            lock_fire_c;
    logic            src_full_c;
    logic [NW-1:0]   cnt_inc_c;
    logic [NW-1:0]   scan_cnt_c;
    logic            piece_hit_c;
    logic [KW-1:0]   disp_kind_c;
    logic            collide_c;

    // Display lookup: bounds first, then piece overlay, then stored cell.
    always_comb begin : disp_lookup
        disp_kind_c = '0;
        piece_hit_c = 1'b0;
        for (int unsigned i = 0; i < NCELL; i++) begin
            if (piece_x[i] == disp_x && piece_y[i] == disp_y) begin
                piece_hit_c = 1'b1;
            end
        end
        if (disp_x < W_LIM && disp_y < H_LIM) begin
            if (piece_valid && piece_hit_c) begin
                disp_kind_c = piece_kind;
            end else begin
                disp_kind_c = board[disp_y][disp_x[XW-1:0]];
            end
        end
    end

    // Collision probe: walls/floor or any occupied stored cell; the falling
    // piece is deliberately not consulted.
    always_comb begin : probe_lookup
        collide_c = 1'b0;
        for (int unsigned i = 0; i < NCELL; i++) begin
            if (q_x[i] >= W_LIM || q_y[i] >= H_LIM) begin
                collide_c = 1'b1;
            end else if (board[q_y[i]][q_x[i][XW-1:0]] != '0) begin
                collide_c = 1'b1;
            end
        end
    end

    // Full-row detect on the current scan source row and saturating count.
    always_comb begin : scan_eval
        src_full_c = 1'b1;
        for (int unsigned c = 0; c < BOARD_W; c++) begin
            if (board[src_row][c] == '0) begin
                src_full_c = 1'b0;
            end
        end
        cnt_inc_c  = (line_cnt >= CNT_MAX) ? CNT_MAX : line_cnt + NW'(1);
        scan_cnt_c = src_full_c ? cnt_inc_c : line_cnt;
    end

    // State register.
    always_ff @(posedge clk) begin : state_reg
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic for the lock / clear sequence.
    always_comb begin : state_next
        state_nxt   = state;
        lock_fire_c = 1'b0;
        case (state)
            IDLE: begin
                lock_fire_c = lock_valid;
                if (lock_valid) begin
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                // Row 0 is the last source row; skip FILL when nothing cleared.
                if (src_row == '0) begin
                    state_nxt = (scan_cnt_c != '0) ? FILL : DONE;
                end
            end
            FILL: begin
                if (fill_left == NW'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Board storage, clear engine datapath and registered outputs.
    always_ff @(posedge clk) begin : datapath
        if (!reset_n) begin
            for (int unsigned r = 0; r < BOARD_H; r++) begin
                board[r] <= '0;
            end
            src_row       <= BOTTOM;
            dst_row       <= BOTTOM;
            line_cnt      <= '0;
            fill_left     <= '0;
            disp_kind     <= '0;
            q_collide     <= 1'b0;
            clear_done    <= 1'b0;
            lines_cleared <= '0;
            lock_ready    <= 1'b1;
            busy          <= 1'b0;
        end else begin
            disp_kind  <= disp_kind_c;
            q_collide  <= collide_c;
            clear_done <= (state_nxt == DONE);
            lock_ready <= (state_nxt == IDLE);
            busy       <= (state_nxt != IDLE);

            // lines_cleared is loaded only when entering DONE, then held.
            if (state_nxt == DONE && state != DONE) begin
                lines_cleared <= (state == SCAN) ? scan_cnt_c : line_cnt;
            end

            case (state)
                IDLE: begin
                    if (lock_fire_c) begin
                        // Off-board cells are dropped; duplicates are harmless.
                        for (int unsigned i = 0; i < NCELL; i++) begin
                            if (lock_x[i] < W_LIM && lock_y[i] < H_LIM) begin
                                board[lock_y[i]][lock_x[i][XW-1:0]] <= lock_kind;
                            end
                        end
                        src_row  <= BOTTOM;
                        dst_row  <= BOTTOM;
                        line_cnt <= '0;
                    end
                end
                SCAN: begin
                    // dst never passes above src, so no unread row is clobbered.
                    if (!src_full_c) begin
                        board[dst_row] <= board[src_row];
                        dst_row        <= dst_row - CW'(1);
                    end
                    src_row  <= src_row - CW'(1);
                    line_cnt <= scan_cnt_c;
                    if (src_row == '0) begin
                        fill_left <= scan_cnt_c;
                    end
                end
                FILL: begin
                    board[dst_row] <= '0;
                    dst_row        <= dst_row - CW'(1);
                    fill_left      <= fill_left - NW'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule
